// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared encodings and constants for the SRAM bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // Wide enough for the 0..7 wait-state range
    localparam int CNT_W = 3;

endpackage

// File: rtl/bus_arb_pick.sv
// rtl/bus_arb_pick.sv - combinational owner selection (policy chosen by BUS_ARB_ROUND_ROBIN_EN)
module bus_arb_pick
    import bus_arb_pkg::*;
(
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic last_owner_i,
    output logic grant_o,
    output logic owner_o
);

    assign grant_o = inst_req_i | data_req_i;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // On a tie the side that did not own the previous access goes first
    always_comb begin
        owner_o = data_req_i ? OWNER_DATA : OWNER_INST;
        if (inst_req_i && data_req_i) begin
            owner_o = (last_owner_i == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
        end
    end
`else
    // Fixed priority: loads/stores always beat fetches
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;

    always_comb begin
        owner_o = data_req_i ? OWNER_DATA : OWNER_INST;
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - fetch/load-store SRAM port arbiter with wait states (option: BUS_ARB_ROUND_ROBIN_EN)
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_ack_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [3:0]        data_sel_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_ack_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic [3:0]        sram_sel_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              pause_req_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              inst_ack_q, inst_ack_d;
    logic              data_ack_q, data_ack_d;
    logic              grant;
    logic              pick_owner;
    logic              last_owner;

    bus_arb_pick u_pick (
        .inst_req_i   (inst_req_i),
        .data_req_i   (data_req_i),
        .last_owner_i (last_owner),
        .grant_o      (grant),
        .owner_o      (pick_owner)
    );

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;
    assign last_owner = last_owner_q;

    // Remember who won the most recent arbitration
    always_ff @(posedge clk) begin
        if (rst) last_owner_q <= OWNER_INST;
        else     last_owner_q <= last_owner_d;
    end

    // Only an IDLE->ACCESS transition changes the remembered owner
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == ST_IDLE && grant) last_owner_d = pick_owner;
    end
`else
    assign last_owner = OWNER_INST;
`endif

    // Next-state logic: latch request in IDLE, count wait states, pulse ack in RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        ce_d         = ce_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d = pick_owner;
                    ce_d    = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_ACCESS;
                    if (pick_owner == OWNER_DATA) begin
                        we_d    = data_we_i;
                        addr_d  = data_addr_i;
                        wdata_d = data_wdata_i;
                        sel_d   = data_sel_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = inst_addr_i;
                        wdata_d = '0;
                        sel_d   = 4'b1111;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Last access cycle: sample the SRAM and release the port
                    if (owner_q == OWNER_DATA) begin
                        data_ack_d = 1'b1;
                        if (!we_q) data_rdata_d = sram_rdata_i;
                    end else begin
                        inst_ack_d   = 1'b1;
                        inst_rdata_d = sram_rdata_i;
                    end
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    sel_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWNER_INST;
            ce_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            ce_q         <= ce_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
        end
    end

    assign sram_ce_o    = ce_q;
    assign sram_we_o    = we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign sram_sel_o   = sel_q;
    assign inst_rdata_o = inst_rdata_q;
    assign data_rdata_o = data_rdata_q;
    assign inst_ack_o   = inst_ack_q;
    assign data_ack_o   = data_ack_q;

    // The pipeline stalls while any request is outstanding and not being acked
    assign pause_req_o = ~rst & ((inst_req_i & ~inst_ack_q) | (data_req_i & ~data_ack_q));

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_sel;
    logic [31:0] sram_rdata;

    logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
    logic        inst_ack, data_ack, sram_ce, sram_we, pause;
    logic [3:0]  sram_sel;

    logic [31:0] z_inst_rdata, z_data_rdata, z_sram_addr, z_sram_wdata;
    logic        z_inst_ack, z_data_ack, z_sram_ce, z_sram_we, z_pause;
    logic [3:0]  z_sram_sel;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr),
        .inst_rdata_o(inst_rdata), .inst_ack_o(inst_ack),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_sel_i(data_sel),
        .data_rdata_o(data_rdata), .data_ack_o(data_ack),
        .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_sel_o(sram_sel),
        .sram_rdata_i(sram_rdata), .pause_req_o(pause)
    );

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr),
        .inst_rdata_o(z_inst_rdata), .inst_ack_o(z_inst_ack),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_sel_i(data_sel),
        .data_rdata_o(z_data_rdata), .data_ack_o(z_data_ack),
        .sram_ce_o(z_sram_ce), .sram_we_o(z_sram_we), .sram_addr_o(z_sram_addr),
        .sram_wdata_o(z_sram_wdata), .sram_sel_o(z_sram_sel),
        .sram_rdata_i(sram_rdata), .pause_req_o(z_pause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0;
        data_addr = 0; data_wdata = 0; data_sel = 0; sram_rdata = 0;
        tick(); tick();

        // Reset state
        chk("rst_ce", sram_ce, 0);       chk("rst_we", sram_we, 0);
        chk("rst_addr", sram_addr, 0);   chk("rst_wdata", sram_wdata, 0);
        chk("rst_sel", sram_sel, 0);     chk("rst_irdata", inst_rdata, 0);
        chk("rst_drdata", data_rdata, 0);chk("rst_iack", inst_ack, 0);
        chk("rst_dack", data_ack, 0);    chk("rst_pause", pause, 0);
        rst = 1'b0;
        tick();

        // Single fetch, WAIT_CYCLES=1: ack at N+3
        inst_req = 1; inst_addr = 32'h8000_0000; sram_rdata = 32'h0280_0413;
        #1;
        chk("f_n_pause", pause, 1);      chk("f_n_ack", inst_ack, 0);
        tick();
        chk("f_n1_ce", sram_ce, 1);      chk("f_n1_addr", sram_addr, 32'h8000_0000);
        chk("f_n1_we", sram_we, 0);      chk("f_n1_sel", sram_sel, 4'hF);
        chk("f_n1_pause", pause, 1);     chk("f_n1_ack", inst_ack, 0);
        tick();
        chk("f_n2_ce", sram_ce, 1);      chk("f_n2_pause", pause, 1);
        chk("f_n2_ack", inst_ack, 0);
        tick();
        chk("f_n3_ack", inst_ack, 1);    chk("f_n3_rdata", inst_rdata, 32'h0280_0413);
        chk("f_n3_pause", pause, 0);     chk("f_n3_ce", sram_ce, 0);
        chk("f_n3_dack", data_ack, 0);
        inst_req = 0;
        tick();
        chk("f_n4_ack", inst_ack, 0);    chk("f_n4_rdata_hold", inst_rdata, 32'h0280_0413);

        // Store: we=1 with sel 0011 for two cycles, then one ack
        data_req = 1; data_we = 1; data_addr = 32'h8040_0010;
        data_wdata = 32'hDEAD_BEEF; data_sel = 4'b0011; sram_rdata = 32'h5555_AAAA;
        tick();
        chk("s_n1_we", sram_we, 1);      chk("s_n1_sel", sram_sel, 4'b0011);
        chk("s_n1_addr", sram_addr, 32'h8040_0010);
        chk("s_n1_wdata", sram_wdata, 32'hDEAD_BEEF);
        tick();
        chk("s_n2_we", sram_we, 1);      chk("s_n2_sel", sram_sel, 4'b0011);
        chk("s_n2_ack", data_ack, 0);
        tick();
        chk("s_n3_ack", data_ack, 1);    chk("s_n3_we", sram_we, 0);
        chk("s_n3_rdata_unchg", data_rdata, 0);
        chk("s_n3_iack", inst_ack, 0);
        data_req = 0; data_we = 0;
        tick();
        chk("s_n4_ack", data_ack, 0);

        // Simultaneous requests (previous owner = data)
        inst_req = 1; inst_addr = 32'h0000_0100;
        data_req = 1; data_we = 0; data_addr = 32'h0000_0200; data_sel = 4'hF;
        sram_rdata = 32'h1111_1111;
        tick();
        chk("sim_first_addr", sram_addr, RR ? 32'h100 : 32'h200);
        tick(); tick();
        chk("sim_first_iack", inst_ack, RR);
        chk("sim_first_dack", data_ack, !RR);
        chk("sim_first_rdata", RR ? inst_rdata : data_rdata, 32'h1111_1111);
        if (RR) inst_req = 0; else data_req = 0;
        tick();
        sram_rdata = 32'h2222_2222;
        chk("sim_gap_iack", inst_ack, 0); chk("sim_gap_dack", data_ack, 0);
        tick();
        chk("sim_second_addr", sram_addr, RR ? 32'h200 : 32'h100);
        tick(); tick();
        chk("sim_second_iack", inst_ack, !RR);
        chk("sim_second_dack", data_ack, RR);
        chk("sim_second_rdata", RR ? data_rdata : inst_rdata, 32'h2222_2222);
        inst_req = 0; data_req = 0;
        tick();

        // Reset during the second ACCESS cycle abandons the access
        inst_req = 1; inst_addr = 32'h0000_0300; sram_rdata = 32'h3333_3333;
        tick(); tick();
        chk("r_access_ce", sram_ce, 1);
        rst = 1;
        tick();
        chk("r_ce", sram_ce, 0);         chk("r_we", sram_we, 0);
        chk("r_addr", sram_addr, 0);     chk("r_sel", sram_sel, 0);
        chk("r_irdata", inst_rdata, 0);  chk("r_drdata", data_rdata, 0);
        chk("r_iack", inst_ack, 0);      chk("r_dack", data_ack, 0);
        chk("r_pause", pause, 0);
        rst = 0; inst_req = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_no_ack", inst_ack, 0);
            chk("r_idle_ce", sram_ce, 0);
        end

        // WAIT_CYCLES=0, back-to-back fetches: ack every third cycle, one cycle wide
        inst_req = 1; inst_addr = 32'h0000_0400; sram_rdata = 32'h4444_4444;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("w0_ack", z_inst_ack, (i % 3) == 2);
        end
        chk("w0_rdata", z_inst_rdata, 32'h4444_4444);
        inst_req = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares one external SRAM port between the instruction-fetch path and the load/store path of the five-stage core. It serialises their requests, inserts a configurable number of SRAM wait states, and returns read data with a one-cycle acknowledge pulse. While any request is pending it raises a pause request to the pipeline controller, which freezes the stages.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `WAIT_CYCLES`, 1, extra SRAM wait cycles per access, legal range 0..7
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous reset, active-high
- `inst_req_i`  in  1  fetch request; held high until `inst_ack_o`
- `inst_addr_i`  in  ADDR_W  fetch address; stable while request is high
- `inst_rdata_o`  out  DATA_W  fetched word; valid when `inst_ack_o`=1
- `inst_ack_o`  out  1  one-cycle completion pulse
- `data_req_i`  in  1  load/store request; held until `data_ack_o`
- `data_we_i`  in  1  1 = store, 0 = load
- `data_addr_i`  in  ADDR_W  data address
- `data_wdata_i`  in  DATA_W  store data
- `data_sel_i`  in  4  byte enables
- `data_rdata_o`  out  DATA_W  load data; valid when `data_ack_o`=1
- `data_ack_o`  out  1  one-cycle completion pulse
- `sram_ce_o`  out  1  SRAM chip enable
- `sram_we_o`  out  1  SRAM write enable
- `sram_addr_o`  out  ADDR_W  SRAM address
- `sram_wdata_o`  out  DATA_W  SRAM write data
- `sram_sel_o`  out  4  SRAM byte enables
- `sram_rdata_i`  in  DATA_W  SRAM read data
- `pause_req_o`  out  1  stall request to the pipeline controller

## Operation
- FSM states and transitions:
  - IDLE: if any request is high, pick an owner, latch its address, write data, byte enables and write enable, load `cnt`=WAIT_CYCLES, then go to ACCESS.
  - ACCESS: drive the latched values onto the SRAM port. If `cnt`≠0, decrement and stay. If `cnt`=0, capture `sram_rdata_i` into the owner's rdata register and go to RESP.
  - RESP: pulse the owner's ack, drive SRAM idle, ignore all requests, then return to IDLE.
- Arbitration: fixed priority, data over instruction; a data request wins on a simultaneous request. See Configuration for the alternative.
- Stores: `sram_we_o`=1 in every ACCESS cycle of a store. The write-path rdata register is unchanged and `data_ack_o` still pulses.
- Loads and fetches: `sram_we_o`=0; `sram_sel_o`=4'b1111 for fetches.
- Request dropped mid-access (e.g. branch flush): the access completes and the ack still pulses. The requester discards it.
- rdata registers hold their last value until the next capture.
- `pause_req_o` = (`inst_req_i` & ~`inst_ack_o`) | (`data_req_i` & ~`data_ack_o`), forced to 0 while `rst`=1.
- Reset:
  - Applies at the next edge; an access in progress is abandoned and no ack is issued.
  - State goes to IDLE.
  - All outputs are 0 after reset: ce, we, addr, wdata, sel, both rdata, both acks, and pause (sel = 4'b0000).

## Timing
- Request high in IDLE cycle N → ACCESS in cycles N+1..N+1+WAIT_CYCLES → ack high in cycle N+2+WAIT_CYCLES.
- Latency is WAIT_CYCLES+2; with the default, a request at N is acked at N+3.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles. RESP always passes through IDLE.
- All SRAM outputs are registered; `sram_addr_o`, `sram_wdata_o`, `sram_sel_o` and `sram_we_o` are stable for the whole ACCESS window.
- `sram_rdata_i` is sampled only on the edge that leaves the last ACCESS cycle.
- A request still high in the cycle after its own ack is treated as a new request.

## Configuration
- Macro: `BUS_ARB_ROUND_ROBIN_EN`.
- Defined: a 1-bit `last_owner` register, reset to instruction. On a simultaneous request the requester that did not own the previous access wins. `last_owner` updates on each IDLE→ACCESS transition.
- Undefined: fixed data-over-instruction priority. No `last_owner` register is built.

## Structure
- Shared package `bus_arb_pkg` holds:
  - the state encoding (IDLE, ACCESS, RESP)
  - owner encoding: `OWNER_INST`=0, `OWNER_DATA`=1
  - the wait-count width constant (3 bits)
- One sub-module, `bus_arb_pick`, is combinational. It takes both requests and `last_owner` and returns the grant and owner; the macro selects its policy.
- The FSM, counter, latches and rdata registers live in `bus_arbiter`.

## Test plan
- Single fetch: `inst_req_i`=1 at addr 0x8000_0000, `sram_rdata_i`=0x0280_0413, WAIT_CYCLES=1 → `inst_ack_o` high exactly at cycle N+3, `inst_rdata_o`=0x0280_0413, `pause_req_o` high cycles N..N+2.
- Store: data store addr 0x8040_0010, wdata 0xDEAD_BEEF, sel 4'b0011 → `sram_we_o`=1 with sel 0011 for 2 cycles, then `data_ack_o` pulses once.
- Simultaneous requests, macro undefined → data is served first and inst is acked WAIT_CYCLES+3 cycles later. Macro defined with previous owner data → inst is served first.
- Reset asserted in the second ACCESS cycle → next cycle all outputs 0, state IDLE, no ack ever issued for that access.
- WAIT_CYCLES=0: back-to-back fetches → acks every 3 cycles, each ack a single cycle wide.
